// File: rtl/dmem_wait_responder_if.sv
// Bus between the MEM stage (master) and the wait-state data memory (slave).
//   Address/WriteData/MemRead/MemWrite/half : request, driven by the pipeline
//   ReadData/Stall/Ready/Fault              : response, driven by the memory
interface dmem_wait_responder_if;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  half;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Ready;
  logic        Fault;

  modport master (
    output Address, WriteData, MemRead, MemWrite, half,
    input  ReadData, Stall, Ready, Fault
  );

  modport slave (
    input  Address, WriteData, MemRead, MemWrite, half,
    output ReadData, Stall, Ready, Fault
  );
endinterface

// File: rtl/dmem_wait_responder.sv
// Data memory with programmable wait states for the MEM stage.
// Each access: IDLE (latch) -> WAITING x WAIT_CYCLES -> ACCESS -> RESP.
// Stall is high from the request in IDLE through ACCESS; Ready (and Fault,
// if the latched request was misaligned or read+write) pulse in RESP.
// Ports:
//   Clk  rising-edge clock
//   Rst  asynchronous active-low reset
//   bus  slave side of dmem_wait_responder_if (request in, response out)
module dmem_wait_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input logic                 Clk,
  input logic                 Rst,
  dmem_wait_responder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WAITING, ACCESS, RESP} state_t;

  state_t              state, nextState;
  logic [3:0]          count;
  logic [ADDR_W-1:0]   wordIdx;
  logic [1:0]          lane;
  logic [1:0]          size;
  logic [31:0]         wdata;
  logic                isRead, isWrite, faultLat;
  logic [31:0]         rdReg;
  logic                req, reqFault, stall;

  logic [31:0] mem [0:(1<<ADDR_W)-1];

  // upper address bits are dropped on purpose: accesses wrap around memory
  logic unusedAddr;
  assign unusedAddr = ^bus.Address[31:ADDR_W+2];

  assign req = bus.MemRead | bus.MemWrite;

  always_comb begin
    reqFault = bus.MemRead & bus.MemWrite;
    if (bus.half == 2'b00 && bus.Address[1:0] != 2'b00) reqFault = 1'b1;
    if (bus.half == 2'b01 && bus.Address[0])            reqFault = 1'b1;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) state <= IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    stall     = 1'b0;
    case (state)
      IDLE: if (req) begin
        stall     = 1'b1;
        nextState = (WAIT_CYCLES == 0) ? ACCESS : WAITING;
      end
      WAITING: begin
        stall = 1'b1;
        if (count == 4'd1) nextState = ACCESS;
      end
      ACCESS: begin
        stall     = 1'b1;
        nextState = RESP;
      end
      RESP: nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // request latch and wait counter
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      count    <= '0;
      wordIdx  <= '0;
      lane     <= '0;
      size     <= '0;
      wdata    <= '0;
      isRead   <= 1'b0;
      isWrite  <= 1'b0;
      faultLat <= 1'b0;
    end else if (state == IDLE && req) begin
      count    <= 4'(WAIT_CYCLES);
      wordIdx  <= bus.Address[ADDR_W+1:2];
      lane     <= bus.Address[1:0];
      size     <= bus.half;
      wdata    <= bus.WriteData;
      isRead   <= bus.MemRead;
      isWrite  <= bus.MemWrite;
      faultLat <= reqFault;
    end else if (state == WAITING) begin
      count <= count - 4'd1;
    end
  end

  // store lanes: data is shifted up to the addressed lane
  logic [3:0]  byteEn;
  logic [31:0] wdataSh;
  always_comb begin
    wdataSh = wdata << {lane, 3'b000};
    case (size)
      2'b00:   byteEn = 4'b1111;
      2'b01:   byteEn = lane[1] ? 4'b1100 : 4'b0011;
      default: byteEn = 4'b0001 << lane;
    endcase
  end

  // array is not reset; Rst gate keeps an interrupted store from committing
  always_ff @(posedge Clk) begin
    if (Rst && state == ACCESS && isWrite && !faultLat) begin
      for (int b = 0; b < 4; b++)
        if (byteEn[b]) mem[wordIdx][b*8 +: 8] <= wdataSh[b*8 +: 8];
    end
  end

  // load: shift selected lanes to bit 0, then extend by size
  logic [31:0] memWord, shifted, loadVal;
  always_comb begin
    memWord = mem[wordIdx];
    shifted = memWord >> {lane, 3'b000};
    case (size)
      2'b00:   loadVal = memWord;
      2'b01:   loadVal = {{16{shifted[15]}}, shifted[15:0]};
      2'b10:   loadVal = {{24{shifted[7]}}, shifted[7:0]};
      default: loadVal = {24'd0, shifted[7:0]};
    endcase
  end

  // stores leave ReadData untouched
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) rdReg <= '0;
    else if (state == ACCESS && isRead) rdReg <= faultLat ? 32'd0 : loadVal;
  end

  assign bus.ReadData = rdReg;
  assign bus.Stall    = Rst & stall;
  assign bus.Ready    = (state == RESP);
  assign bus.Fault    = (state == RESP) & faultLat;

endmodule

// File: tb/tb_dmem_wait_responder.sv
module tb_dmem_wait_responder;
  logic Clk = 1'b0;
  logic Rst = 1'b0;
  int   nChecks = 0;
  int   nErrors = 0;

  always #5 Clk = ~Clk;

  dmem_wait_responder_if ifA();
  dmem_wait_responder_if ifB();

  dmem_wait_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dutA (.Clk(Clk), .Rst(Rst), .bus(ifA));
  dmem_wait_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dutB (.Clk(Clk), .Rst(Rst), .bus(ifB));

  task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic drive(input bit useB, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data, input logic [1:0] hs);
    if (useB) begin
      ifB.MemRead = rd; ifB.MemWrite = wr; ifB.Address = addr; ifB.WriteData = data; ifB.half = hs;
    end else begin
      ifA.MemRead = rd; ifA.MemWrite = wr; ifA.Address = addr; ifA.WriteData = data; ifA.half = hs;
    end
  endtask

  // One access: request held until its RESP; returns Ready cycle index
  // (0 = IDLE cycle of the request), stall count, ReadData and Fault in RESP.
  task automatic doAcc(input bit useB, input bit rd, input bit wr,
                       input logic [31:0] addr, input logic [31:0] data, input logic [1:0] hs,
                       output int lat, output int stalls, output logic [31:0] rdata, output logic flt);
    logic st, rdy;
    lat = -1; stalls = 0; rdata = '0; flt = 1'b0;
    @(posedge Clk); #1;
    drive(useB, rd, wr, addr, data, hs);
    for (int c = 0; c < 40 && lat < 0; c++) begin
      @(negedge Clk);
      st  = useB ? ifB.Stall : ifA.Stall;
      rdy = useB ? ifB.Ready : ifA.Ready;
      if (st) stalls++;
      if (rdy) begin
        lat   = c;
        rdata = useB ? ifB.ReadData : ifA.ReadData;
        flt   = useB ? ifB.Fault : ifA.Fault;
      end
    end
    if (lat < 0) checkVal("timeout", 32'd0, 32'd1);
    @(posedge Clk); #1;
    drive(useB, 1'b0, 1'b0, addr, data, hs);
    @(negedge Clk);
    checkVal("readyOnce", useB ? ifB.Ready : ifA.Ready, 32'd0);
    checkVal("idleStall", useB ? ifB.Stall : ifA.Stall, 32'd0);
  endtask

  initial begin
    int lat, st, stallB, readyB;
    int rdyIdx[2];
    logic [31:0] rdv[2];
    logic [31:0] rd;
    logic f;

    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 2'b00);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00);
    #12;
    checkVal("rstStall", ifA.Stall, 32'd0);
    checkVal("rstReady", ifA.Ready, 32'd0);
    checkVal("rstFault", ifA.Fault, 32'd0);
    checkVal("rstData", ifA.ReadData, 32'd0);
    ifA.MemRead = 1'b0;
    #11 Rst = 1'b1;

    // word round trip, 2 wait states
    doAcc(0, 0, 1, 32'h10, 32'hDEADBEEF, 2'b00, lat, st, rd, f);
    checkVal("stLat", lat, 32'd4);
    checkVal("stStall", st, 32'd4);
    checkVal("stHoldRd", rd, 32'd0);
    checkVal("stFault", f, 32'd0);
    doAcc(0, 1, 0, 32'h10, 32'h0, 2'b00, lat, st, rd, f);
    checkVal("ldLat", lat, 32'd4);
    checkVal("ldStall", st, 32'd4);
    checkVal("ldData", rd, 32'hDEADBEEF);

    // sub-word lanes
    doAcc(0, 0, 1, 32'h20, 32'h11223344, 2'b00, lat, st, rd, f);
    doAcc(0, 0, 1, 32'h22, 32'h000000AA, 2'b10, lat, st, rd, f);
    checkVal("byteStFault", f, 32'd0);
    doAcc(0, 1, 0, 32'h20, 32'h0, 2'b00, lat, st, rd, f);
    checkVal("byteMerge", rd, 32'h11AA3344);
    doAcc(0, 1, 0, 32'h22, 32'h0, 2'b01, lat, st, rd, f);
    checkVal("halfSx", rd, 32'h000011AA);
    doAcc(0, 1, 0, 32'h22, 32'h0, 2'b10, lat, st, rd, f);
    checkVal("byteSx", rd, 32'hFFFFFFAA);
    doAcc(0, 1, 0, 32'h22, 32'h0, 2'b11, lat, st, rd, f);
    checkVal("byteZx", rd, 32'h000000AA);

    // misalignment
    doAcc(0, 0, 1, 32'h30, 32'h0BADF00D, 2'b00, lat, st, rd, f);
    doAcc(0, 1, 0, 32'h30, 32'h0, 2'b00, lat, st, rd, f);
    checkVal("preMis", rd, 32'h0BADF00D);
    doAcc(0, 0, 1, 32'h31, 32'h12345678, 2'b00, lat, st, rd, f);
    checkVal("misStFault", f, 32'd1);
    checkVal("misStLat", lat, 32'd4);
    checkVal("misStHold", rd, 32'h0BADF00D);
    doAcc(0, 1, 0, 32'h30, 32'h0, 2'b00, lat, st, rd, f);
    checkVal("misNoWrite", rd, 32'h0BADF00D);
    checkVal("alignFault", f, 32'd0);
    doAcc(0, 1, 0, 32'h33, 32'h0, 2'b01, lat, st, rd, f);
    checkVal("misLdFault", f, 32'd1);
    checkVal("misLdData", rd, 32'd0);
    doAcc(0, 1, 1, 32'h30, 32'h0, 2'b00, lat, st, rd, f);
    checkVal("rwFault", f, 32'd1);

    // wrap-around
    doAcc(0, 0, 1, 32'h1000, 32'h5A5A5A5A, 2'b00, lat, st, rd, f);
    doAcc(0, 1, 0, 32'h0000, 32'h0, 2'b00, lat, st, rd, f);
    checkVal("wrap", rd, 32'h5A5A5A5A);

    // zero wait states, back-to-back loads
    doAcc(1, 0, 1, 32'h50, 32'h11111111, 2'b00, lat, st, rd, f);
    checkVal("w0Lat", lat, 32'd2);
    checkVal("w0Stall", st, 32'd2);
    doAcc(1, 0, 1, 32'h54, 32'h22222222, 2'b00, lat, st, rd, f);
    @(posedge Clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h50, 32'h0, 2'b00);
    stallB = 0; readyB = 0; rdyIdx[0] = -1; rdyIdx[1] = -1; rdv[0] = '0; rdv[1] = '0;
    for (int c = 0; c < 8; c++) begin
      @(negedge Clk);
      if (ifB.Stall) stallB++;
      if (ifB.Ready) begin
        if (readyB < 2) begin rdyIdx[readyB] = c; rdv[readyB] = ifB.ReadData; end
        readyB++;
      end
      if (c == 2) begin @(posedge Clk); #1 ifB.Address = 32'h54; end
      if (c == 5) begin @(posedge Clk); #1 ifB.MemRead = 1'b0; end
    end
    checkVal("b2bStall", stallB, 32'd4);
    checkVal("b2bReadyCnt", readyB, 32'd2);
    checkVal("b2bFirst", rdyIdx[0], 32'd2);
    checkVal("b2bGap", rdyIdx[1] - rdyIdx[0], 32'd3);
    checkVal("b2bData0", rdv[0], 32'h11111111);
    checkVal("b2bData1", rdv[1], 32'h22222222);

    // reset during wait states abandons the store
    doAcc(0, 0, 1, 32'h40, 32'h01020304, 2'b00, lat, st, rd, f);
    doAcc(0, 1, 0, 32'h40, 32'h0, 2'b00, lat, st, rd, f);
    checkVal("preRst", rd, 32'h01020304);
    @(posedge Clk); #1;
    drive(1'b0, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 2'b00);
    @(negedge Clk);
    @(negedge Clk);
    checkVal("inWait", ifA.Stall, 32'd1);
    #2 Rst = 1'b0;
    #1;
    checkVal("midRstStall", ifA.Stall, 32'd0);
    checkVal("midRstReady", ifA.Ready, 32'd0);
    checkVal("midRstData", ifA.ReadData, 32'd0);
    ifA.MemWrite = 1'b0;
    @(posedge Clk); @(posedge Clk); #3 Rst = 1'b1;
    doAcc(0, 1, 0, 32'h40, 32'h0, 2'b00, lat, st, rd, f);
    checkVal("rstNoWrite", rd, 32'h01020304);

    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end
endmodule
